// File: rtl/route_header_inserter.sv
// -----------------------------------------------------------------------------
// route_header_inserter
//
// Purpose: looks up the destination/source route of every H2C packet in the
// lookup DPRAMs (port A, 1-cycle read latency) on its first beat. A routed
// packet leaves as one header beat (destination in tdata[DESTINATION_BITS-1:0],
// source in tdata[32+:SOURCE_BITS]) followed by the unmodified packet. A packet
// whose destination reads back as 0 is dropped whole. Outputs are fully
// registered: an output register plus one hold (skid) register.
//
// Ports:
//   AXI_clock, AXI_reset        clock, synchronous active-high reset
//   AXIS_IN_*                   upstream packet stream (first beat carries keys)
//   AXIS_OUT_*                  downstream stream (header + payload)
//   LOOKUP_enable/_address      DPRAM port A enable and addresses
//   LOOKUP_*_data               DPRAM port A read data (valid 1 cycle later)
//   STAT_forwarded/_dropped     wrapping packet counters
// -----------------------------------------------------------------------------
module route_header_inserter #(
    parameter int KEY_BITS         = 8,
    parameter int DESTINATION_BITS = 16,
    parameter int SOURCE_BITS      = 16
) (
    input  logic                        AXI_clock,
    input  logic                        AXI_reset,
    input  logic [63:0]                 AXIS_IN_tdata,
    input  logic [7:0]                  AXIS_IN_tkeep,
    input  logic                        AXIS_IN_tlast,
    input  logic                        AXIS_IN_tvalid,
    output logic                        AXIS_IN_tready,
    output logic [63:0]                 AXIS_OUT_tdata,
    output logic [7:0]                  AXIS_OUT_tkeep,
    output logic                        AXIS_OUT_tlast,
    output logic                        AXIS_OUT_tvalid,
    input  logic                        AXIS_OUT_tready,
    output logic                        LOOKUP_enable,
    output logic [KEY_BITS-1:0]         LOOKUP_destination_address,
    output logic [KEY_BITS-1:0]         LOOKUP_source_address,
    input  logic [DESTINATION_BITS-1:0] LOOKUP_destination_data,
    input  logic [SOURCE_BITS-1:0]      LOOKUP_source_data,
    output logic [31:0]                 STAT_forwarded,
    output logic [31:0]                 STAT_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_HEADER,
        S_BODY,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_out_valid;
    logic [63:0] r_out_data;
    logic [7:0]  r_out_keep;
    logic        r_out_last;

    logic        r_hold_valid;
    logic [63:0] r_hold_data;
    logic [7:0]  r_hold_keep;
    logic        r_hold_last;

    logic [63:0] r_header;
    logic [31:0] r_stat_forwarded;
    logic [31:0] r_stat_dropped;

    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_out_free;
    logic        w_route;
    logic [63:0] w_header;
    logic        w_load_hdr;
    logic        w_hdr_live;
    logic        w_drop;
    logic        w_hold_to_out;
    logic        w_in_to_out;
    logic        w_in_to_hold;
    logic        w_fwd_inc;

    // Output register can take a new beat when empty or being consumed now.
    assign w_out_free = ~r_out_valid | AXIS_OUT_tready;
    assign w_route    = (LOOKUP_destination_data != '0);
    assign w_fwd_inc  = r_out_valid & AXIS_OUT_tready & r_out_last;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready = ~r_hold_valid;
            S_BODY:  w_in_ready = ~r_hold_valid;
            S_DROP:  w_in_ready = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
        if (AXI_reset) begin
            w_in_ready = 1'b0;
        end
    end

    assign AXIS_IN_tready = w_in_ready;
    assign w_in_fire      = AXIS_IN_tvalid & w_in_ready;

    assign LOOKUP_enable              = w_in_fire & (r_state == S_IDLE);
    assign LOOKUP_source_address      = AXIS_IN_tdata[KEY_BITS-1:0];
    assign LOOKUP_destination_address = AXIS_IN_tdata[2*KEY_BITS-1:KEY_BITS];

    always_comb begin
        w_header                         = '0;
        w_header[DESTINATION_BITS-1:0]   = LOOKUP_destination_data;
        w_header[32 +: SOURCE_BITS]      = LOOKUP_source_data;
    end

    // A held first beat that is also the last beat needs no BODY phase: after
    // the header goes out the FSM returns to IDLE, where the hold still drains
    // before the next packet's first beat is accepted.
    always_comb begin
        w_next_state = r_state;
        w_load_hdr   = 1'b0;
        w_hdr_live   = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) w_next_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (!w_route) begin
                    w_drop       = 1'b1;
                    w_next_state = r_hold_last ? S_IDLE : S_DROP;
                end else if (w_out_free) begin
                    w_load_hdr   = 1'b1;
                    w_hdr_live   = 1'b1;
                    w_next_state = r_hold_last ? S_IDLE : S_BODY;
                end else begin
                    w_next_state = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_out_free) begin
                    w_load_hdr   = 1'b1;
                    w_next_state = r_hold_last ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                if (w_in_fire && AXIS_IN_tlast) w_next_state = S_IDLE;
            end
            S_DROP: begin
                if (w_in_fire && AXIS_IN_tlast) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Hold always drains ahead of new input so beat order is preserved; while
    // the header is pending (LOOKUP/HEADER) the held first beat must wait.
    assign w_hold_to_out = r_hold_valid & w_out_free &
                           ((r_state == S_IDLE) | (r_state == S_BODY));
    assign w_in_to_out   = w_in_fire & (r_state == S_BODY) & w_out_free & ~r_hold_valid;
    assign w_in_to_hold  = w_in_fire & ((r_state == S_IDLE) |
                                        ((r_state == S_BODY) & ~w_out_free));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge AXI_clock) begin
        if (AXI_reset) begin
            r_state          <= S_IDLE;
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_out_keep       <= '0;
            r_out_last       <= 1'b0;
            r_hold_valid     <= 1'b0;
            r_stat_forwarded <= '0;
            r_stat_dropped   <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_load_hdr) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_hdr_live ? w_header : r_header;
                r_out_keep  <= 8'hFF;
                r_out_last  <= 1'b0;
            end else if (w_hold_to_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_hold_data;
                r_out_keep  <= r_hold_keep;
                r_out_last  <= r_hold_last;
            end else if (w_in_to_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= AXIS_IN_tdata;
                r_out_keep  <= AXIS_IN_tkeep;
                r_out_last  <= AXIS_IN_tlast;
            end else if (AXIS_OUT_tready) begin
                r_out_valid <= 1'b0;
            end

            if (w_in_to_hold) begin
                r_hold_valid <= 1'b1;
            end else if (w_hold_to_out || w_drop) begin
                r_hold_valid <= 1'b0;
            end

            if (w_fwd_inc) r_stat_forwarded <= r_stat_forwarded + 32'd1;
            if (w_drop)    r_stat_dropped   <= r_stat_dropped + 32'd1;
        end
    end

    // NOTE: hold and header payload registers carry no reset; their contents
    // are only observed behind a valid flag that is itself reset.
    always_ff @(posedge AXI_clock) begin
        if (w_in_to_hold) begin
            r_hold_data <= AXIS_IN_tdata;
            r_hold_keep <= AXIS_IN_tkeep;
            r_hold_last <= AXIS_IN_tlast;
        end
        if (r_state == S_LOOKUP) begin
            r_header <= w_header;
        end
    end

    assign AXIS_OUT_tvalid = r_out_valid;
    assign AXIS_OUT_tdata  = r_out_data;
    assign AXIS_OUT_tkeep  = r_out_keep;
    assign AXIS_OUT_tlast  = r_out_last;
    assign STAT_forwarded  = r_stat_forwarded;
    assign STAT_dropped    = r_stat_dropped;

endmodule

// File: tb/tb_route_header_inserter.sv
// -----------------------------------------------------------------------------
// tb_route_header_inserter
//
// Purpose: self-checking bench for route_header_inserter. A registered DPRAM
// model answers lookups; a scoreboard queue receives the expected header and
// payload beats when a packet is driven and is popped on each output handshake.
// -----------------------------------------------------------------------------
module tb_route_header_inserter;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        AXI_clock = 1'b0;
    logic        AXI_reset;
    logic [63:0] AXIS_IN_tdata;
    logic [7:0]  AXIS_IN_tkeep;
    logic        AXIS_IN_tlast;
    logic        AXIS_IN_tvalid;
    logic        AXIS_IN_tready;
    logic [63:0] AXIS_OUT_tdata;
    logic [7:0]  AXIS_OUT_tkeep;
    logic        AXIS_OUT_tlast;
    logic        AXIS_OUT_tvalid;
    logic        AXIS_OUT_tready;
    logic        LOOKUP_enable;
    logic [7:0]  LOOKUP_destination_address;
    logic [7:0]  LOOKUP_source_address;
    logic [15:0] LOOKUP_destination_data;
    logic [15:0] LOOKUP_source_data;
    logic [31:0] STAT_forwarded;
    logic [31:0] STAT_dropped;

    route_header_inserter dut (
        .AXI_clock                  (AXI_clock),
        .AXI_reset                  (AXI_reset),
        .AXIS_IN_tdata              (AXIS_IN_tdata),
        .AXIS_IN_tkeep              (AXIS_IN_tkeep),
        .AXIS_IN_tlast              (AXIS_IN_tlast),
        .AXIS_IN_tvalid             (AXIS_IN_tvalid),
        .AXIS_IN_tready             (AXIS_IN_tready),
        .AXIS_OUT_tdata             (AXIS_OUT_tdata),
        .AXIS_OUT_tkeep             (AXIS_OUT_tkeep),
        .AXIS_OUT_tlast             (AXIS_OUT_tlast),
        .AXIS_OUT_tvalid            (AXIS_OUT_tvalid),
        .AXIS_OUT_tready            (AXIS_OUT_tready),
        .LOOKUP_enable              (LOOKUP_enable),
        .LOOKUP_destination_address (LOOKUP_destination_address),
        .LOOKUP_source_address      (LOOKUP_source_address),
        .LOOKUP_destination_data    (LOOKUP_destination_data),
        .LOOKUP_source_data         (LOOKUP_source_data),
        .STAT_forwarded             (STAT_forwarded),
        .STAT_dropped               (STAT_dropped)
    );

    always #5 AXI_clock = ~AXI_clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    longint      cyc      = 0;
    longint      hs_cyc[$];
    beat_t       sb_q[$];
    logic [31:0] exp_fwd;
    logic [31:0] exp_drop;
    int          rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: stalled

    logic [15:0] dest_mem [256];
    logic [15:0] src_mem  [256];
    logic [15:0] dest_q;
    logic [15:0] src_q;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge AXI_clock) cyc = cyc + 1;

    // Lookup DPRAM port A model, 1-cycle read latency.
    always @(posedge AXI_clock) begin
        if (LOOKUP_enable) begin
            dest_q <= dest_mem[LOOKUP_destination_address];
            src_q  <= src_mem[LOOKUP_source_address];
        end
    end
    assign LOOKUP_destination_data = dest_q;
    assign LOOKUP_source_data      = src_q;

    initial begin
        AXIS_OUT_tready = 1'b1;
        forever begin
            @(posedge AXI_clock);
            #1;
            case (rdy_mode)
                1:       AXIS_OUT_tready = 1'($urandom_range(0, 1));
                2:       AXIS_OUT_tready = 1'b0;
                default: AXIS_OUT_tready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard, stall stability, skid back-pressure.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    always @(negedge AXI_clock) begin
        if (AXI_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(AXIS_OUT_tvalid), 64'd1);
                check("stall_data", AXIS_OUT_tdata, prev_data);
            end
            if (dut.r_hold_valid) check("in_ready_hold_full", 64'(AXIS_IN_tready), 64'd0);
            if (AXIS_OUT_tvalid && AXIS_OUT_tready) begin
                hs_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 64'(sb_q.size()), 64'd1);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    check("out_data", AXIS_OUT_tdata, e.data);
                    check("out_keep", 64'(AXIS_OUT_tkeep), 64'(e.keep));
                    check("out_last", 64'(AXIS_OUT_tlast), 64'(e.last));
                end
            end
            prev_stall = AXIS_OUT_tvalid & ~AXIS_OUT_tready;
            prev_data  = AXIS_OUT_tdata;
        end
    end

    // Drive one beat starting just after a posedge; returns just after the
    // posedge on which it was accepted.
    task automatic drive_beat(input beat_t b, input bit first, input logic [7:0] dkey,
                              input logic [7:0] skey, output int stalls);
        bit done = 1'b0;
        AXIS_IN_tdata  = b.data;
        AXIS_IN_tkeep  = b.keep;
        AXIS_IN_tlast  = b.last;
        AXIS_IN_tvalid = 1'b1;
        stalls = 0;
        while (!done) begin
            @(negedge AXI_clock);
            if (AXIS_IN_tready) begin
                check(first ? "lookup_en_first" : "lookup_en_body", 64'(LOOKUP_enable), 64'(first));
                if (first) begin
                    check("dest_addr", 64'(LOOKUP_destination_address), 64'(dkey));
                    check("src_addr", 64'(LOOKUP_source_address), 64'(skey));
                end
                @(posedge AXI_clock);
                #1;
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 2000) begin
                    check("in_timeout", 64'(stalls), 64'd0);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_packet(input logic [7:0] dkey, input logic [7:0] skey, input int nbeats,
                               output int stalls, output longint acc_cyc);
        bit    route;
        beat_t b;
        int    st;
        route   = (dest_mem[dkey] != 16'd0);
        stalls  = 0;
        acc_cyc = 0;
        if (route) begin
            b.data = {16'h0, src_mem[skey], 16'h0, dest_mem[dkey]};
            b.keep = 8'hFF;
            b.last = 1'b0;
            sb_q.push_back(b);
            exp_fwd = exp_fwd + 32'd1;
        end else begin
            exp_drop = exp_drop + 32'd1;
        end
        for (int i = 0; i < nbeats; i++) begin
            b.data = {$urandom, $urandom};
            if (i == 0) b.data[15:0] = {dkey, skey};
            b.keep = 8'($urandom);
            b.last = (i == nbeats - 1);
            if (route) sb_q.push_back(b);
            drive_beat(b, i == 0, dkey, skey, st);
            stalls += st;
            if (i == 0) acc_cyc = cyc;
        end
        AXIS_IN_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge AXI_clock);
            if (sb_q.size() == 0 && !AXIS_OUT_tvalid) break;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge AXI_clock);
        #1;
    endtask

    task automatic check_stats(input string tag);
        @(negedge AXI_clock);
        check({tag, "_fwd"}, 64'(STAT_forwarded), 64'(exp_fwd));
        check({tag, "_drop"}, 64'(STAT_dropped), 64'(exp_drop));
        @(posedge AXI_clock);
        #1;
    endtask

    initial begin
        int          st;
        longint      acc;
        logic [7:0]  rk [3];
        logic [7:0]  sk [3];

        foreach (dest_mem[i]) begin
            dest_mem[i] = 16'd0;
            src_mem[i]  = 16'd0;
        end
        dest_mem[3]   = 16'h00AB;
        dest_mem[7]   = 16'h0042;
        dest_mem[12]  = 16'hFFFF;
        src_mem[5]    = 16'h1234;
        src_mem[2]    = 16'hBEEF;
        src_mem[200]  = 16'h8001;
        rk = '{8'd3, 8'd7, 8'd12};
        sk = '{8'd5, 8'd2, 8'd200};
        exp_fwd  = 32'd0;
        exp_drop = 32'd0;

        AXI_reset      = 1'b1;
        AXIS_IN_tvalid = 1'b1;
        AXIS_IN_tdata  = 64'h0;
        AXIS_IN_tkeep  = 8'h0;
        AXIS_IN_tlast  = 1'b0;
        repeat (3) @(posedge AXI_clock);
        @(negedge AXI_clock);
        check("rst_out_valid", 64'(AXIS_OUT_tvalid), 64'd0);
        check("rst_out_data", AXIS_OUT_tdata, 64'd0);
        check("rst_out_keep", 64'(AXIS_OUT_tkeep), 64'd0);
        check("rst_out_last", 64'(AXIS_OUT_tlast), 64'd0);
        check("rst_in_ready", 64'(AXIS_IN_tready), 64'd0);
        check("rst_lookup_en", 64'(LOOKUP_enable), 64'd0);
        check("rst_fwd", 64'(STAT_forwarded), 64'd0);
        check("rst_drop", 64'(STAT_dropped), 64'd0);
        @(posedge AXI_clock);
        #1;
        AXI_reset      = 1'b0;
        AXIS_IN_tvalid = 1'b0;
        @(posedge AXI_clock);
        #1;

        // Routed 3-beat packet, header at t+2, payload at t+3..t+5.
        hs_cyc.delete();
        send_packet(8'd3, 8'd5, 3, st, acc);
        wait_drain();
        check("hs_count_t1", 64'(hs_cyc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_cyc.size()) check("latency_t1", 64'(hs_cyc[i] - acc), 64'(i + 1));
        end
        check_stats("t1");

        // Dropped 4-beat packet, then a routed one.
        hs_cyc.delete();
        send_packet(8'd9, 8'd5, 4, st, acc);
        check("drop_in_stalls", 64'(st), 64'd1);
        wait_drain();
        check("drop_no_output", 64'(hs_cyc.size()), 64'd0);
        check_stats("t2_drop");
        send_packet(8'd7, 8'd2, 3, st, acc);
        wait_drain();
        check_stats("t2_route");

        // 100 back-to-back single-beat routed packets.
        hs_cyc.delete();
        for (int p = 0; p < 100; p++) begin
            send_packet(rk[p % 3], sk[$urandom_range(0, 2)], 1, st, acc);
        end
        wait_drain();
        check("hs_count_t3", 64'(hs_cyc.size()), 64'd200);
        check_stats("t3");

        // 16-beat packet with 50% downstream ready.
        rdy_mode = 1;
        send_packet(8'd12, 8'd200, 16, st, acc);
        wait_drain();
        rdy_mode = 0;
        check_stats("t4");

        // Reset in BODY with header in output and first beat in hold.
        rdy_mode = 2;
        @(posedge AXI_clock);
        #1;
        begin
            beat_t b;
            b.data = {48'h5555_6666_7777, 8'd3, 8'd5};
            b.keep = 8'hFF;
            b.last = 1'b0;
            drive_beat(b, 1'b1, 8'd3, 8'd5, st);
        end
        AXIS_IN_tvalid = 1'b0;
        repeat (2) @(posedge AXI_clock);
        @(negedge AXI_clock);
        check("pre_rst_valid", 64'(AXIS_OUT_tvalid), 64'd1);
        check("pre_rst_header", AXIS_OUT_tdata, 64'h0000_1234_0000_00AB);
        check("pre_rst_in_ready", 64'(AXIS_IN_tready), 64'd0);
        @(posedge AXI_clock);
        #1;
        AXI_reset = 1'b1;
        @(posedge AXI_clock);
        @(negedge AXI_clock);
        check("mid_rst_valid", 64'(AXIS_OUT_tvalid), 64'd0);
        check("mid_rst_fwd", 64'(STAT_forwarded), 64'd0);
        check("mid_rst_drop", 64'(STAT_dropped), 64'd0);
        check("mid_rst_in_ready", 64'(AXIS_IN_tready), 64'd0);
        @(posedge AXI_clock);
        #1;
        AXI_reset = 1'b0;
        exp_fwd   = 32'd0;
        exp_drop  = 32'd0;
        sb_q.delete();
        rdy_mode  = 0;
        @(posedge AXI_clock);
        #1;
        send_packet(8'd3, 8'd2, 2, st, acc);
        wait_drain();
        check_stats("t5");

        // Forwarded counter wrap.
        force dut.r_stat_forwarded = 32'hFFFF_FFFF;
        @(posedge AXI_clock);
        #1;
        release dut.r_stat_forwarded;
        @(negedge AXI_clock);
        check("preload_fwd", 64'(STAT_forwarded), 64'hFFFF_FFFF);
        exp_fwd = 32'hFFFF_FFFF;
        @(posedge AXI_clock);
        #1;
        send_packet(8'd7, 8'd5, 2, st, acc);
        wait_drain();
        check("wrap_expect", 64'(exp_fwd), 64'd0);
        check_stats("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
